// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready input and gapless back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of each frame.
module piso_serializer #(
   parameter int unsigned WIDTH      = 16,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             msb_first,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             done,
   output logic             busy
);

   localparam int unsigned     CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
   typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

   state_t           r_state, w_state_next;
   logic [WIDTH-1:0] r_shreg, w_shreg_next;
   logic [CW-1:0]    r_cnt, w_cnt_next;
   logic             r_msb, w_msb_next;
   logic             r_first, w_first_next;
   logic             r_done, w_done_next;
   logic             w_last_data;
   logic             w_last;
   logic             w_accept;
   logic             w_data_bit;
`ifdef PISO_PARITY_EN
   logic             r_par, w_par_next;
`endif

   assign w_last_data = (r_state == S_SHIFT) && (r_cnt == LAST_IDX);
`ifdef PISO_PARITY_EN
   assign w_last      = (r_state == S_PARITY);
`else
   assign w_last      = w_last_data;
`endif

   // The next word is taken on the same edge that retires the last bit.
   assign in_ready   = (r_state == S_IDLE) | (w_last & shift_en);
   assign w_accept   = in_valid & in_ready;
   assign w_data_bit = r_msb ? r_shreg[WIDTH-1] : r_shreg[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_msb   <= 1'b0;
         r_first <= 1'b0;
         r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         r_shreg <= w_shreg_next;
         r_cnt   <= w_cnt_next;
         r_msb   <= w_msb_next;
         r_first <= w_first_next;
         r_done  <= w_done_next;
`ifdef PISO_PARITY_EN
         r_par   <= w_par_next;
`endif
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_shreg_next = r_shreg;
      w_cnt_next   = r_cnt;
      w_msb_next   = r_msb;
      w_first_next = r_first;
      w_done_next  = w_last & shift_en;
`ifdef PISO_PARITY_EN
      w_par_next   = r_par;
`endif

      case (r_state)
         S_SHIFT: begin
            if (shift_en) begin
               w_first_next = 1'b0;
               if (w_last_data) begin
`ifdef PISO_PARITY_EN
                  w_state_next = S_PARITY;
`else
                  w_state_next = S_IDLE;
`endif
               end else begin
                  w_cnt_next   = r_cnt + CW'(1);
                  w_shreg_next = r_msb ? {r_shreg[WIDTH-2:0], 1'b0}
                                       : {1'b0, r_shreg[WIDTH-1:1]};
               end
            end
         end
`ifdef PISO_PARITY_EN
         S_PARITY: begin
            if (shift_en) begin
               w_state_next = S_IDLE;
            end
         end
`endif
         default: begin
         end
      endcase

      // Loading overrides the end-of-frame return to idle.
      if (w_accept) begin
         w_state_next = S_SHIFT;
         w_shreg_next = in_data;
         w_cnt_next   = '0;
         w_msb_next   = msb_first;
         w_first_next = 1'b1;
`ifdef PISO_PARITY_EN
         w_par_next   = ^in_data;
`endif
      end
   end

   assign ser_valid   = (r_state != S_IDLE);
   assign busy        = ser_valid;
   assign frame_start = r_first;
   assign done        = r_done;
`ifdef PISO_PARITY_EN
   assign ser_out = !ser_valid ? IDLE_LEVEL : ((r_state == S_PARITY) ? r_par : w_data_bit);
`else
   assign ser_out = ser_valid ? w_data_bit : IDLE_LEVEL;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a frame-as-bit-list reference model predicts every output
// each cycle under directed and random stimulus.
module tb_piso_serializer;

   localparam int   W     = 8;
   localparam logic IDLE  = 1'b1;
`ifdef PISO_PARITY_EN
   localparam int   FRAME = W + 1;
`else
   localparam int   FRAME = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         msb_first;
   logic         shift_en;
   logic         ser_out;
   logic         ser_valid;
   logic         frame_start;
   logic         done;
   logic         busy;

   piso_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .msb_first   (msb_first),
      .shift_en    (shift_en),
      .ser_out     (ser_out),
      .ser_valid   (ser_valid),
      .frame_start (frame_start),
      .done        (done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   logic [5:0] dut_outs;
   assign dut_outs = {ser_valid, ser_out, frame_start, done, in_ready, busy};

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the frame in flight as a list of bits, plus a position.
   logic m_bits[$];
   int   m_idx      = 0;
   bit   m_active   = 0;
   bit   m_done     = 0;
   bit   m_accepted = 0;

   int obs_done  = 0;
   int obs_valid = 0;
   int obs_run   = 0;
   int obs_max   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_last();
      return m_active && (m_idx == m_bits.size() - 1);
   endfunction

   function automatic logic [5:0] model_outs();
      logic rdy;
      rdy = !m_active || (model_last() && shift_en);
      return {m_active, (m_active ? m_bits[m_idx] : IDLE), (m_active && m_idx == 0),
              m_done, rdy, m_active};
   endfunction

   task automatic model_advance();
      logic rdy;
      logic acc;
      if (!rst_n) begin
         m_active   = 0;
         m_done     = 0;
         m_accepted = 0;
         return;
      end
      rdy        = !m_active || (model_last() && shift_en);
      acc        = in_valid && rdy;
      m_done     = model_last() && shift_en;
      m_accepted = acc;
      if (m_active && shift_en) begin
         m_idx++;
         if (m_idx == m_bits.size()) m_active = 0;
      end
      if (acc) begin
         m_bits.delete();
         for (int i = 0; i < W; i++)
            m_bits.push_back(msb_first ? in_data[W-1-i] : in_data[i]);
`ifdef PISO_PARITY_EN
         m_bits.push_back(^in_data);
`endif
         m_idx    = 0;
         m_active = 1;
      end
   endtask

   task automatic run_cycle();
      @(negedge clk);
      check("outs", 32'(dut_outs), 32'(model_outs()));
      if (done) obs_done++;
      if (ser_valid) begin
         obs_valid++;
         obs_run++;
         if (obs_run > obs_max) obs_max = obs_run;
      end else begin
         obs_run = 0;
      end
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic present(input logic [W-1:0] word, input logic msb);
      int n;
      n         = 0;
      in_valid  = 1'b1;
      in_data   = word;
      msb_first = msb;
      do begin
         run_cycle();
         n++;
      end while (!m_accepted && n < 100);
      if (!m_accepted) check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      bit pending;
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      msb_first = 1'b0;
      shift_en  = 1'b0;
      #2;
      check("rst_state", 32'(dut_outs), 32'({1'b0, IDLE, 1'b0, 1'b0, 1'b1, 1'b0}));
      in_valid = 1'b1;
      idle_cycles(2);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      idle_cycles(2);

      // A5 MSB first, continuous shift
      shift_en = 1'b1;
      present(8'hA5, 1'b1);
      idle_cycles(FRAME + 2);

      // A5 LSB first, inputs churn mid-frame
      present(8'hA5, 1'b0);
      for (int i = 0; i < FRAME + 2; i++) begin
         msb_first = ~msb_first;
         in_data   = W'($urandom);
         run_cycle();
      end

      // 0F LSB first, shift every 4th cycle
      n         = 0;
      in_valid  = 1'b1;
      in_data   = 8'h0F;
      msb_first = 1'b0;
      for (int i = 0; i < 4 * FRAME + 8; i++) begin
         shift_en = (n % 4 == 3);
         run_cycle();
         n++;
         if (m_accepted) in_valid = 1'b0;
      end

      // Back-to-back 81 then 7E
      shift_en  = 1'b1;
      obs_done  = 0;
      obs_valid = 0;
      obs_max   = 0;
      obs_run   = 0;
      present(8'h81, 1'b1);
      present(8'h7E, 1'b1);
      idle_cycles(FRAME + 3);
      check("b2b_done", 32'(obs_done), 32'd2);
      check("b2b_valid", 32'(obs_valid), 32'(2 * FRAME));
      check("b2b_contig", 32'(obs_max), 32'(2 * FRAME));

      // Asynchronous reset mid-frame at bit 3
      obs_done = 0;
      present(8'hC3, 1'b1);
      n = 0;
      while (!(m_active && m_idx == 3) && n < 20) begin
         run_cycle();
         n++;
      end
      check("reach_bit3", 32'(m_idx), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst", 32'(dut_outs), 32'({1'b0, IDLE, 1'b0, 1'b0, 1'b1, 1'b0}));
      m_active = 0;
      m_done   = 0;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      idle_cycles(3);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      idle_cycles(FRAME + 2);
      check("rst_no_done", 32'(obs_done), 32'd0);
      present(8'h3C, 1'b0);
      idle_cycles(FRAME + 2);
      check("post_rst_done", 32'(obs_done), 32'd1);

      // Parity examples (plain frames in the default build)
      present(8'h07, 1'b1);
      idle_cycles(FRAME + 1);
      present(8'h03, 1'b0);
      idle_cycles(FRAME + 1);

      // Randomized traffic
      pending = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!pending) begin
            in_data = W'($urandom);
            if ($urandom_range(0, 2) == 0) pending = 1;
         end
         in_valid  = pending;
         msb_first = 1'($urandom_range(0, 1));
         shift_en  = ($urandom_range(0, 3) != 0);
         run_cycle();
         if (m_accepted) pending = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
